// File: rtl/multicycle_control_if.sv
// Handshake/control bundle between the multi-cycle MIPS control FSM and the datapath.
// master = control FSM side, slave = datapath side.
interface multicycle_control_if #(
   parameter int ALUOP_W = 4
);
   logic [5:0]         opcode;
   logic               Zero;
   logic               MemReady;
   logic               PCWrite;
   logic               IorD;
   logic               IRWrite;
   logic               MemRead;
   logic               MemWrite;
   logic               MemToReg;
   logic               RegDst;
   logic               RegWrite;
   logic               Link;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [ALUOP_W-1:0] ALUOp;
   logic [1:0]         PCSource;
   logic [3:0]         State;
   logic               Trap;

   modport master (
      input  opcode, Zero, MemReady,
      output PCWrite, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst, RegWrite,
             Link, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, Trap
   );

   modport slave (
      output opcode, Zero, MemReady,
      input  PCWrite, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst, RegWrite,
             Link, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, Trap
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with memory-ready timeout trap.
// Build option: CONTROL_ILLEGAL_TRAP_EN makes unlisted opcodes trap instead of executing as NOP.
//
// state    | meaning
// IDLE     | post-reset, outputs quiet, go to FETCH
// FETCH    | read instruction at PC, PC+4 into PC on MemReady
// DECODE   | compute branch target, dispatch on opcode
// MEM_ADDR | rs + imm for lw/sw
// MEM_RD   | data read at ALUOut
// MEM_WB   | MDR -> rt
// MEM_WR   | data write at ALUOut
// R_EXEC   | rs op rt
// R_WB     | ALUOut -> rd
// BRANCH   | compare rs/rt, load target on condition
// JUMP     | load jump target, link for jal
// I_EXEC   | rs op imm
// I_WB     | ALUOut -> rt
// TRAP     | halted until reset
module multicycle_control #(
   parameter int ALUOP_W     = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input logic                  clock,
   input logic                  reset,
   multicycle_control_if.master bus
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEM_ADDR = 4'd3,
      MEM_RD   = 4'd4,
      MEM_WB   = 4'd5,
      MEM_WR   = 4'd6,
      R_EXEC   = 4'd7,
      R_WB     = 4'd8,
      BRANCH   = 4'd9,
      JUMP     = 4'd10,
      I_EXEC   = 4'd11,
      I_WB     = 4'd12,
      TRAP     = 4'd15
   } state_t;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // Counter holds the number of unanswered cycles so far; the access traps on
   // the MEM_TIMEOUT-th unanswered cycle, but a ready in that cycle still wins.
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [5:0] op_q;
   logic [7:0] wait_cnt;
   logic       in_wait;
   logic       timeout;

   logic       pc_write;
   logic       iord;
   logic       ir_write;
   logic       mem_read;
   logic       mem_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       link;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [3:0] alu_op;
   logic [1:0] pc_source;

   assign in_wait = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
   assign timeout = in_wait && !bus.MemReady && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         op_q     <= 6'd0;
         wait_cnt <= 8'd0;
      end else begin
         state <= state_nxt;
         if (state == DECODE)
            op_q <= bus.opcode;
         if (state_nxt != state)
            wait_cnt <= 8'd0;
         else if (in_wait && !bus.MemReady)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     state_nxt = FETCH;
         FETCH: begin
            if (bus.MemReady)
               state_nxt = DECODE;
            else if (timeout)
               state_nxt = TRAP;
         end
         DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW:    state_nxt = MEM_ADDR;
               OP_R:            state_nxt = R_EXEC;
               OP_BEQ, OP_BNE:  state_nxt = BRANCH;
               OP_J, OP_JAL:    state_nxt = JUMP;
               OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
               OP_ORI, OP_XORI, OP_LUI:
                                state_nxt = I_EXEC;
`ifdef CONTROL_ILLEGAL_TRAP_EN
               default:         state_nxt = TRAP;
`else
               default:         state_nxt = FETCH;
`endif
            endcase
         end
         MEM_ADDR: state_nxt = (op_q == OP_LW) ? MEM_RD : MEM_WR;
         MEM_RD: begin
            if (bus.MemReady)
               state_nxt = MEM_WB;
            else if (timeout)
               state_nxt = TRAP;
         end
         MEM_WB:   state_nxt = FETCH;
         MEM_WR: begin
            if (bus.MemReady)
               state_nxt = FETCH;
            else if (timeout)
               state_nxt = TRAP;
         end
         R_EXEC:   state_nxt = R_WB;
         R_WB:     state_nxt = FETCH;
         BRANCH:   state_nxt = FETCH;
         JUMP:     state_nxt = FETCH;
         I_EXEC:   state_nxt = I_WB;
         I_WB:     state_nxt = FETCH;
         TRAP:     state_nxt = TRAP;
         default:  state_nxt = TRAP;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      link       = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 4'b0000;
      pc_source  = 2'd0;
      case (state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'd1;
            ir_write  = bus.MemReady;
            pc_write  = bus.MemReady;
         end
         DECODE: begin
            alu_src_b = 2'd3;
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 4'b1111;
         end
         R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            pc_source = 2'd1;
            if (op_q == OP_BNE) begin
               alu_op   = 4'b0101;
               pc_write = !bus.Zero;
            end else begin
               alu_op   = 4'b0100;
               pc_write = bus.Zero;
            end
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'd2;
            if (op_q == OP_JAL) begin
               reg_write = 1'b1;
               link      = 1'b1;
            end
         end
         I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            case (op_q)
               OP_ADDI:  alu_op = 4'b1000;
               OP_SLTI:  alu_op = 4'b1010;
               OP_SLTIU: alu_op = 4'b1011;
               OP_ANDI:  alu_op = 4'b1100;
               OP_ORI:   alu_op = 4'b1101;
               OP_XORI:  alu_op = 4'b1110;
               OP_LUI:   alu_op = 4'b0011;
               default:  alu_op = 4'b0000;
            endcase
         end
         I_WB: begin
            reg_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.PCWrite  = pc_write;
   assign bus.IorD     = iord;
   assign bus.IRWrite  = ir_write;
   assign bus.MemRead  = mem_read;
   assign bus.MemWrite = mem_write;
   assign bus.MemToReg = mem_to_reg;
   assign bus.RegDst   = reg_dst;
   assign bus.RegWrite = reg_write;
   assign bus.Link     = link;
   assign bus.ALUSrcA  = alu_src_a;
   assign bus.ALUSrcB  = alu_src_b;
   assign bus.ALUOp    = ALUOP_W'(alu_op);
   assign bus.PCSource = pc_source;
   assign bus.State    = state;
   assign bus.Trap     = (state == TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into its expected
// per-cycle phase sequence (with random memory latencies) and compared cycle by cycle.
module tb_multicycle_control;

   localparam int TO = 15;

   localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2, S_MADDR = 4'd3,
                          S_MRD  = 4'd4,  S_MWB   = 4'd5,  S_MWR    = 4'd6, S_REXEC = 4'd7,
                          S_RWB  = 4'd8,  S_BR    = 4'd9,  S_JMP    = 4'd10, S_IEXEC = 4'd11,
                          S_IWB  = 4'd12, S_TRAP  = 4'd15;

   localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BR = 3, C_J = 4, C_I = 5, C_ILL = 6;

   logic clock = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   multicycle_control_if #(.ALUOP_W(4)) bus ();

   multicycle_control #(.ALUOP_W(4), .MEM_TIMEOUT(TO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clock = ~clock;

   logic [18:0] out_vec;
   assign out_vec = {bus.PCWrite, bus.IorD, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.MemToReg,
                     bus.RegDst, bus.RegWrite, bus.Link, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                     bus.PCSource, bus.Trap};

   function automatic logic [18:0] mk(input bit pcw, input bit iord, input bit irw, input bit mrd,
                                      input bit mwr, input bit m2r, input bit rdst, input bit rw,
                                      input bit lnk, input bit asa, input logic [1:0] asb,
                                      input logic [3:0] aop, input logic [1:0] pcs, input bit trap);
      return {pcw, iord, irw, mrd, mwr, m2r, rdst, rw, lnk, asa, asb, aop, pcs, trap};
   endfunction

   function automatic bit rb();
      return 1'($urandom);
   endfunction

   function automatic int iclass(input logic [5:0] op);
      case (op)
         6'b100011: return C_LW;
         6'b101011: return C_SW;
         6'b000000: return C_R;
         6'b000100, 6'b000101: return C_BR;
         6'b000010, 6'b000011: return C_J;
         6'b001000, 6'b001010, 6'b001011, 6'b001100,
         6'b001101, 6'b001110, 6'b001111: return C_I;
         default: return C_ILL;
      endcase
   endfunction

   function automatic logic [3:0] ialu(input logic [5:0] op);
      case (op)
         6'b001000: return 4'b1000;
         6'b001010: return 4'b1010;
         6'b001011: return 4'b1011;
         6'b001100: return 4'b1100;
         6'b001101: return 4'b1101;
         6'b001110: return 4'b1110;
         default:   return 4'b0011;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Inputs are applied just after a rising edge; outputs are checked on the falling edge.
   task automatic cyc(input string tag, input logic [3:0] st, input logic [18:0] exp,
                      input bit rdy, input bit zf);
      bus.MemReady = rdy;
      bus.Zero     = zf;
      @(negedge clock);
      check({tag, "_state"}, 32'(bus.State), 32'(st));
      check({tag, "_out"}, 32'(out_vec), 32'(exp));
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.MemReady = rb();
      @(negedge clock);
      check("reset_state", 32'(bus.State), 32'(S_IDLE));
      check("reset_out", 32'(out_vec), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      cyc("idle", S_IDLE, 19'd0, rb(), rb());
   endtask

   task automatic trap_hold(input string tag);
      for (int k = 0; k < 3; k++)
         cyc(tag, S_TRAP, mk(0,0,0,0,0,0,0,0,0,0,2'd0,4'd0,2'd0,1), rb(), rb());
   endtask

   // w unanswered cycles then ready; w >= TO means the access never answers in time.
   task automatic wait_phase(input string tag, input logic [3:0] st, input logic [18:0] e_lo,
                             input logic [18:0] e_hi, input int w, output bit trapped);
      trapped = 1'b0;
      for (int k = 0; k < w && k < TO; k++)
         cyc(tag, st, e_lo, 1'b0, rb());
      if (w >= TO) begin
         trapped = 1'b1;
         trap_hold({tag, "_timeout"});
         do_reset();
      end else begin
         cyc(tag, st, e_hi, 1'b1, rb());
      end
   endtask

   task automatic run_instr(input logic [5:0] op, input bit z, input int fw, input int mw);
      bit trapped;
      int cls;
      logic [18:0] e;
      cls = iclass(op);
      bus.opcode = op;
      wait_phase("fetch", S_FETCH, mk(0,0,0,1,0,0,0,0,0,0,2'd1,4'd0,2'd0,0),
                 mk(1,0,1,1,0,0,0,0,0,0,2'd1,4'd0,2'd0,0), fw, trapped);
      if (trapped) return;
      cyc("decode", S_DECODE, mk(0,0,0,0,0,0,0,0,0,0,2'd3,4'd0,2'd0,0), rb(), rb());
      bus.opcode = 6'($urandom);
      case (cls)
         C_LW: begin
            cyc("lw_addr", S_MADDR, mk(0,0,0,0,0,0,0,0,0,1,2'd2,4'd0,2'd0,0), rb(), rb());
            e = mk(0,1,0,1,0,0,0,0,0,0,2'd0,4'd0,2'd0,0);
            wait_phase("lw_rd", S_MRD, e, e, mw, trapped);
            if (!trapped)
               cyc("lw_wb", S_MWB, mk(0,0,0,0,0,1,0,1,0,0,2'd0,4'd0,2'd0,0), rb(), rb());
         end
         C_SW: begin
            cyc("sw_addr", S_MADDR, mk(0,0,0,0,0,0,0,0,0,1,2'd2,4'd0,2'd0,0), rb(), rb());
            e = mk(0,1,0,0,1,0,0,0,0,0,2'd0,4'd0,2'd0,0);
            wait_phase("sw_wr", S_MWR, e, e, mw, trapped);
         end
         C_R: begin
            cyc("r_exec", S_REXEC, mk(0,0,0,0,0,0,0,0,0,1,2'd0,4'b1111,2'd0,0), rb(), rb());
            cyc("r_wb", S_RWB, mk(0,0,0,0,0,0,1,1,0,0,2'd0,4'd0,2'd0,0), rb(), rb());
         end
         C_I: begin
            cyc("i_exec", S_IEXEC, mk(0,0,0,0,0,0,0,0,0,1,2'd2,ialu(op),2'd0,0), rb(), rb());
            cyc("i_wb", S_IWB, mk(0,0,0,0,0,0,0,1,0,0,2'd0,4'd0,2'd0,0), rb(), rb());
         end
         C_BR: begin
            if (op[0])
               cyc("bne", S_BR, mk(!z,0,0,0,0,0,0,0,0,1,2'd0,4'b0101,2'd1,0), rb(), z);
            else
               cyc("beq", S_BR, mk(z,0,0,0,0,0,0,0,0,1,2'd0,4'b0100,2'd1,0), rb(), z);
         end
         C_J: begin
            cyc("jump", S_JMP, mk(1,0,0,0,0,0,0,op[0],op[0],0,2'd0,4'd0,2'd2,0), rb(), rb());
         end
         default: begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
            trap_hold("illegal_trap");
            do_reset();
`endif
         end
      endcase
   endtask

   function automatic logic [5:0] rand_op();
      logic [5:0] legal [14];
      legal = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b000010, 6'b000011,
                6'b001000, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
      if ($urandom_range(0, 19) == 0)
         return 6'($urandom);
      return legal[$urandom_range(0, 13)];
   endfunction

   function automatic int rand_wait();
      int r;
      r = int'($urandom_range(0, 39));
      if (r == 0)
         return TO;
      if (r < 10)
         return int'($urandom_range(0, TO - 1));
      return 0;
   endfunction

   initial begin
      bus.opcode   = 6'd0;
      bus.Zero     = 1'b0;
      bus.MemReady = 1'b0;
      reset        = 1'b1;
      do_reset();

      // directed cases
      run_instr(6'b100011, 1'b0, 0, 0);
      run_instr(6'b000100, 1'b1, 0, 0);
      run_instr(6'b000101, 1'b1, 0, 0);
      run_instr(6'b000100, 1'b0, 0, 0);
      run_instr(6'b000011, 1'b0, 0, 0);
      run_instr(6'b000010, 1'b0, 0, 0);
      run_instr(6'b101011, 1'b0, 0, TO - 1);
      run_instr(6'b111111, 1'b0, 0, 0);
      run_instr(6'b100011, 1'b0, TO - 1, TO - 1);

      // reset while a load is waiting on memory
      bus.opcode = 6'b100011;
      cyc("abort_fetch", S_FETCH, mk(1,0,1,1,0,0,0,0,0,0,2'd1,4'd0,2'd0,0), 1'b1, rb());
      cyc("abort_decode", S_DECODE, mk(0,0,0,0,0,0,0,0,0,0,2'd3,4'd0,2'd0,0), rb(), rb());
      cyc("abort_addr", S_MADDR, mk(0,0,0,0,0,0,0,0,0,1,2'd2,4'd0,2'd0,0), rb(), rb());
      cyc("abort_rd", S_MRD, mk(0,1,0,1,0,0,0,0,0,0,2'd0,4'd0,2'd0,0), 1'b0, rb());
      do_reset();

      // store that never answers
      run_instr(6'b101011, 1'b0, 0, TO);

      for (int i = 0; i < 250; i++)
         run_instr(rand_op(), rb(), rand_wait(), rand_wait());

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
